tdc_channel_arb_mux: RTL and testbench
======================================

// Module: tdc_channel_arb_mux
// PURPOSE
//  Registered N:1 channel multiplexer with valid/ready handshakes for the Sigma Delta DAQ TDC output path.
//  Selects one of WIDTH channel words, either round-robin over all pending channels or from a fixed channel.
//  Presents the word on a single downstream stream, one word per cycle at full throughput.
//  Sits between the per-channel TDC result registers and the output serializer/FIFO.
// PARAMETERS
//  WIDTH        16   number of input channels (>=2)
//  DATA_LENGTH  68   bits per channel word
// PORTS
//  i_clk        in   1                     clock, all state on rising edge
//  i_reset_n    in   1                     asynchronous active-low reset
//  i_sel        in   $clog2(WIDTH+1)       0 = round-robin; k in 1..WIDTH = fixed channel k-1; >WIDTH = no grant
//  i_data       in   DATA_LENGTH x WIDTH   unpacked array of channel words
//  i_valid      in   WIDTH                 per-channel word available
//  o_ready      out  WIDTH                 per-channel accept; one-hot or zero, combinational
//  o_data       out  DATA_LENGTH           registered output word
//  o_valid      out  1                     o_data holds an unconsumed word
//  i_ready      in   1                     downstream accepts o_data this cycle
//  o_chan       out  $clog2(WIDTH)         channel of o_data (present only with TDC_MUX_CHAN_TAG_EN)
// BEHAVIOUR
//  Reset: o_valid=0, o_data=0, o_chan=0, rr pointer=WIDTH-1 (channel 0 has first priority); o_ready=0 while reset asserted.
//  Output register states: EMPTY (o_valid=0), FULL (o_valid=1).
//  Load enable: ld = EMPTY | (FULL & i_ready).
//  Grant: when ld, the arbiter picks channel g from eligible set E; o_ready[g]=1 iff ld & i_valid[g] & g in E.
//  Transfer on channel g occurs when o_ready[g] & i_valid[g]. The word is then registered and visible next cycle (latency 1).
//  E: i_sel=0 -> all channels with i_valid; i_sel=k<=WIDTH -> {k-1} if i_valid[k-1]; i_sel>WIDTH -> empty.
//  Round-robin: search starts at pointer+1 and wraps modulo WIDTH. Pointer updates to g only on a transfer in i_sel=0 mode.
//   Fixed-mode transfers leave the pointer unchanged.
//  Transitions: EMPTY->FULL on transfer; FULL->EMPTY on i_ready with no transfer;
//   FULL->FULL on i_ready with transfer (back-to-back) or on !i_ready (hold).
//  Hold rule: while FULL & !i_ready, o_data, o_chan and o_valid are stable and o_ready is all zero.
//  o_valid never drops without i_ready.
//  i_sel is sampled each cycle. Changing it only affects the next grant; a held word is never altered or dropped.
//  Upstream may drop i_valid without a transfer; no grant is made that cycle.
//  Reset mid-operation: a held word is discarded, and state returns to the reset values immediately (asynchronously).
//  Width rules: the pointer and g are $clog2(WIDTH) bits. Wrap is explicit modulo WIDTH, so a WIDTH that is not a power of 2 never yields an index >= WIDTH.
// CONFIGURATION
//  TDC_MUX_CHAN_TAG_EN defined: o_chan port exists and is registered alongside o_data with the granted index.
//  TDC_MUX_CHAN_TAG_EN undefined: no o_chan port and no tag flop. All other behaviour is identical.
// STRUCTURE
//  Package tdc_mux_pkg:
//   - typedef enum logic {MUX_EMPTY, MUX_FULL} mux_state_t
//   - localparam SEL_RR = 0
//   - function rr_next(ptr, req) returning the first set bit after ptr, with wrap
//  Sub-module rr_arbiter #(WIDTH):
//   - inputs: req, ptr
//   - outputs: one-hot gnt and index; purely combinational
//  Top level: eligibility masking, ld/ready logic, output register, pointer register.
// TESTING
//  1 Reset: assert i_reset_n=0 mid-stream with o_valid=1 -> o_valid=0, o_ready=0 asynchronously; after release, channel 0 wins first.
//  2 RR fairness: i_sel=0, all 16 i_valid=1, i_ready=1 -> o_chan sequence 0,1,...,15,0 with one word per cycle and no bubbles.
//  3 Backpressure: i_ready=0 for 5 cycles with o_valid=1 -> o_data stable, o_ready=0; on i_ready=1 the next word loads the same cycle.
//  4 Fixed mode: i_sel=5, i_valid=16'hFFFF -> only channel 4 granted. With i_sel=17 -> no grants, o_valid falls after drain.
//  5 Sparse/wrap: i_sel=0, i_valid only on ch 3 and 15, pointer at 15 -> grants 3,15,3. WIDTH=12 build -> index never >=12.
//  6 Mode switch mid-hold: FULL on ch 7 with i_ready=0, then i_sel changes to 2 -> ch 7 word delivered intact, then ch 1 granted.

Source files
------------

// File: rtl/tdc_mux_pkg.sv
// Shared types and round-robin search helper for the TDC channel arbiter/mux.
// The optional channel tag is enabled with TDC_MUX_CHAN_TAG_EN.
package tdc_mux_pkg;

    typedef enum logic {MUX_EMPTY, MUX_FULL} mux_state_t;

    localparam int SEL_RR    = 0;
    localparam int MAX_CHAN  = 64;

    // First set bit of req strictly after ptr, wrapping modulo width; returns ptr if none.
    function automatic int rr_next(input int width, input int ptr,
                                   input logic [MAX_CHAN-1:0] req);
        int found;
        int idx;
        logic hit;
        found = ptr;
        hit   = 1'b0;
        for (int off = 1; off <= MAX_CHAN; off++) begin
            if (off <= width && !hit) begin
                idx = ptr + off;
                if (idx >= width) begin
                    idx = idx - width;
                end
                if (req[idx[5:0]]) begin
                    found = idx;
                    hit   = 1'b1;
                end
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/tdc_channel_arb_mux_if.sv
// Upstream channel bundle plus downstream stream of the TDC channel mux.
// o_chan exists only when TDC_MUX_CHAN_TAG_EN is defined.
interface tdc_channel_arb_mux_if #(
    parameter int WIDTH       = 16,
    parameter int DATA_LENGTH = 68
);
    localparam int SEL_W  = $clog2(WIDTH + 1);
    localparam int CHAN_W = $clog2(WIDTH);

    logic [SEL_W-1:0]       i_sel;
    logic [DATA_LENGTH-1:0] i_data [WIDTH];
    logic [WIDTH-1:0]       i_valid;
    logic [WIDTH-1:0]       o_ready;
    logic [DATA_LENGTH-1:0] o_data;
    logic                   o_valid;
    logic                   i_ready;
`ifdef TDC_MUX_CHAN_TAG_EN
    logic [CHAN_W-1:0]      o_chan;
`endif

    modport slave (
        input  i_sel, i_data, i_valid, i_ready,
`ifdef TDC_MUX_CHAN_TAG_EN
        output o_chan,
`endif
        output o_ready, o_data, o_valid
    );

    modport master (
        output i_sel, i_data, i_valid, i_ready,
`ifdef TDC_MUX_CHAN_TAG_EN
        input  o_chan,
`endif
        input  o_ready, o_data, o_valid
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, wrapping.
module rr_arbiter
    import tdc_mux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]         req,
    input  logic [$clog2(WIDTH)-1:0] ptr,
    output logic [WIDTH-1:0]         gnt,
    output logic [$clog2(WIDTH)-1:0] idx
);
    localparam int CHAN_W = $clog2(WIDTH);

    logic any_req;

    assign any_req = |req;
    assign idx     = CHAN_W'(rr_next(WIDTH, 32'(ptr), MAX_CHAN'(req)));

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gnt
            assign gnt[gi] = any_req && (idx == CHAN_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/tdc_channel_arb_mux.sv
// Registered N:1 TDC channel mux, round-robin or fixed-channel selection, one word per cycle.
// Define TDC_MUX_CHAN_TAG_EN to register the granted channel index on o_chan.
module tdc_channel_arb_mux
    import tdc_mux_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DATA_LENGTH = 68
) (
    input  logic i_clk,
    input  logic i_reset_n,
    tdc_channel_arb_mux_if.slave bus
);
    localparam int SEL_W  = $clog2(WIDTH + 1);
    localparam int CHAN_W = $clog2(WIDTH);

    mux_state_t             state_reg, state_next;
    logic [CHAN_W-1:0]      ptr_reg, ptr_next;
    logic [DATA_LENGTH-1:0] data_reg, data_next;
    logic [WIDTH-1:0]       elig;
    logic [WIDTH-1:0]       gnt;
    logic [WIDTH-1:0]       ready;
    logic [CHAN_W-1:0]      gnt_idx;
    logic                   rr_mode;
    logic                   ld;
    logic                   xfer;

    assign rr_mode = (bus.i_sel == SEL_W'(SEL_RR));

    // Fixed mode leaves at most one eligible bit, so the same arbiter serves both modes.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_elig
            assign elig[gi] = bus.i_valid[gi] && (rr_mode || (bus.i_sel == SEL_W'(gi + 1)));
        end
    endgenerate

    rr_arbiter #(.WIDTH(WIDTH)) u_arb (
        .req (elig),
        .ptr (ptr_reg),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        data_next  = data_reg;
        ready      = '0;
        ld         = (state_reg == MUX_EMPTY) || bus.i_ready;
        if (ld && i_reset_n) begin
            ready = gnt;
        end
        xfer = |ready;

        case (state_reg)
            MUX_EMPTY: if (xfer) state_next = MUX_FULL;
            MUX_FULL:  if (bus.i_ready && !xfer) state_next = MUX_EMPTY;
            default:   state_next = MUX_EMPTY;
        endcase

        if (xfer) begin
            data_next = bus.i_data[gnt_idx];
            if (rr_mode) begin
                ptr_next = gnt_idx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg <= MUX_EMPTY;
            ptr_reg   <= CHAN_W'(WIDTH - 1);
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            data_reg  <= data_next;
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = (state_reg == MUX_FULL);
    assign bus.o_data  = data_reg;

`ifdef TDC_MUX_CHAN_TAG_EN
    logic [CHAN_W-1:0] chan_reg;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            chan_reg <= '0;
        end else if (xfer) begin
            chan_reg <= gnt_idx;
        end
    end

    assign bus.o_chan = chan_reg;
`endif

endmodule

// File: tb/tb_tdc_channel_arb_mux.sv
// Directed self-checking bench for tdc_channel_arb_mux (16-channel and 12-channel builds).
module tb_tdc_channel_arb_mux;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    tdc_channel_arb_mux_if #(.WIDTH(16), .DATA_LENGTH(68)) bus ();
    tdc_channel_arb_mux_if #(.WIDTH(12), .DATA_LENGTH(68)) bus12 ();

    tdc_channel_arb_mux #(.WIDTH(16), .DATA_LENGTH(68)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    tdc_channel_arb_mux #(.WIDTH(12), .DATA_LENGTH(68)) dut12 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [67:0] word(input int k);
        return {4'h9, 32'h1000_0000 + 32'(k), ~32'(k)};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        for (int k = 0; k < 16; k++) bus.i_data[k] = word(k);
        for (int k = 0; k < 12; k++) bus12.i_data[k] = word(k);
        bus.i_sel     = '0;
        bus.i_valid   = 16'hFFFF;
        bus.i_ready   = 1'b0;
        bus12.i_sel   = '0;
        bus12.i_valid = '0;
        bus12.i_ready = 1'b0;

        // reset state, ready gated while in reset
        repeat (3) tick();
        check_eq("rst_valid", 128'(bus.o_valid), 128'(1'b0));
        check_eq("rst_data",  128'(bus.o_data),  128'(68'h0));
        check_eq("rst_ready", 128'(bus.o_ready), 128'(16'h0000));
        rst_n = 1'b1;
        #1;
        check_eq("first_grant", 128'(bus.o_ready), 128'(16'h0001));
        tick();
        check_eq("first_valid", 128'(bus.o_valid), 128'(1'b1));
        check_eq("first_data",  128'(bus.o_data),  128'(word(0)));
        check_eq("first_hold_ready", 128'(bus.o_ready), 128'(16'h0000));

        // backpressure: hold for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_data",  128'(bus.o_data),  128'(word(0)));
            check_eq("bp_ready", 128'(bus.o_ready), 128'(16'h0000));
            check_eq("bp_valid", 128'(bus.o_valid), 128'(1'b1));
        end
        bus.i_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", 128'(bus.o_ready), 128'(16'h0002));
        tick();
        check_eq("bp_release_data", 128'(bus.o_data), 128'(word(1)));

        // round-robin over all channels, one word per cycle
        for (int n = 0; n < 17; n++) begin
            int c;
            c = (2 + n) % 16;
            tick();
            check_eq("rr_data",  128'(bus.o_data),  128'(word(c)));
            check_eq("rr_valid", 128'(bus.o_valid), 128'(1'b1));
`ifdef TDC_MUX_CHAN_TAG_EN
            check_eq("rr_chan", 128'(bus.o_chan), 128'(c));
`endif
        end

        // fixed channel 4 (i_sel=5); pointer stays at 2
        bus.i_sel = 5'd5;
        #1;
        check_eq("fix_ready", 128'(bus.o_ready), 128'(16'h0010));
        tick();
        check_eq("fix_data1", 128'(bus.o_data), 128'(word(4)));
        check_eq("fix_ready2", 128'(bus.o_ready), 128'(16'h0010));
        tick();
        check_eq("fix_data2", 128'(bus.o_data), 128'(word(4)));

        // out-of-range select: no grants, output drains
        bus.i_sel = 5'd17;
        #1;
        check_eq("nogrant_ready", 128'(bus.o_ready), 128'(16'h0000));
        tick();
        check_eq("drain_valid1", 128'(bus.o_valid), 128'(1'b0));
        tick();
        check_eq("drain_valid2", 128'(bus.o_valid), 128'(1'b0));
        bus.i_sel = 5'd0;
        #1;
        check_eq("ptr_kept_ready", 128'(bus.o_ready), 128'(16'h0008));

        // sparse requests with wrap: move pointer to 15, then 3,15,3
        bus.i_valid = 16'h8000;
        #1;
        check_eq("sp_ready15", 128'(bus.o_ready), 128'(16'h8000));
        tick();
        check_eq("sp_data15", 128'(bus.o_data), 128'(word(15)));
        bus.i_valid = 16'h8008;
        #1;
        check_eq("sp_ready_a", 128'(bus.o_ready), 128'(16'h0008));
        tick();
        check_eq("sp_data_a", 128'(bus.o_data), 128'(word(3)));
        check_eq("sp_ready_b", 128'(bus.o_ready), 128'(16'h8000));
        tick();
        check_eq("sp_data_b", 128'(bus.o_data), 128'(word(15)));
        check_eq("sp_ready_c", 128'(bus.o_ready), 128'(16'h0008));
        tick();
        check_eq("sp_data_c", 128'(bus.o_data), 128'(word(3)));

        // mode switch while holding channel 7
        bus.i_valid = 16'h0080;
        #1;
        check_eq("ms_ready7", 128'(bus.o_ready), 128'(16'h0080));
        tick();
        bus.i_ready = 1'b0;
        bus.i_valid = 16'hFFFF;
        #1;
        check_eq("ms_hold_ready", 128'(bus.o_ready), 128'(16'h0000));
        bus.i_sel = 5'd2;
        #1;
        check_eq("ms_sel_ready", 128'(bus.o_ready), 128'(16'h0000));
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("ms_hold_data",  128'(bus.o_data),  128'(word(7)));
            check_eq("ms_hold_valid", 128'(bus.o_valid), 128'(1'b1));
        end
        bus.i_ready = 1'b1;
        #1;
        check_eq("ms_next_ready", 128'(bus.o_ready), 128'(16'h0002));
        tick();
        check_eq("ms_next_data", 128'(bus.o_data), 128'(word(1)));

        // asynchronous reset while holding a word
        bus.i_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_valid", 128'(bus.o_valid), 128'(1'b0));
        check_eq("ar_ready", 128'(bus.o_ready), 128'(16'h0000));
        check_eq("ar_data",  128'(bus.o_data),  128'(68'h0));
        repeat (2) tick();
        rst_n = 1'b1;
        bus.i_sel = 5'd0;
        #1;
        check_eq("ar_first_ready", 128'(bus.o_ready), 128'(16'h0001));
        tick();
        check_eq("ar_first_data", 128'(bus.o_data), 128'(word(0)));

        // 12-channel build: wrap stays below 12
        bus12.i_ready = 1'b1;
        bus12.i_valid = 12'hFFF;
        #1;
        check_eq("w12_first_ready", 128'(bus12.o_ready), 128'(12'h001));
        for (int n = 0; n < 13; n++) begin
            tick();
            check_eq("w12_data", 128'(bus12.o_data), 128'(word(n % 12)));
`ifdef TDC_MUX_CHAN_TAG_EN
            check_eq("w12_chan", 128'(bus12.o_chan), 128'(n % 12));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
